reg_display_scan: RTL and testbench

Downstream consumer of the CPU datapath's four 4-bit register outputs (R3..R0). Snapshots the register values once per full scan and drives a 4-digit, common-anode, multiplexed seven-segment display, one hexadecimal digit per register. It provides a refresh prescaler, an anti-ghosting blanking interval per digit, and a freeze input. Outputs depend only on internal registers, never combinationally on the inputs.

---
 rtl/reg_display_scan_pkg.sv | 28 ++
 rtl/reg_display_scan_hex_to_7seg.sv | 31 +++
 rtl/reg_display_scan.sv | 87 ++++++++
 tb/tb_reg_display_scan.sv | 132 +++++++++++++
 4 files changed

// File: rtl/reg_display_scan_pkg.sv
// Shared display constants: active-low segment encodings, digit count and
// the all-dark anode pattern for the multiplexed seven-segment scanner.
package reg_display_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Segment order {g,f,e,d,c,b,a}, low = lit
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/reg_display_scan_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
    import reg_display_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/reg_display_scan.sv
// Four-digit multiplexed hex display of datapath registers R3..R0, with
// per-scan snapshot, refresh prescaler, per-slot blanking and freeze.
module reg_display_scan
    import reg_display_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 7352,
    parameter int unsigned BLANK       = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] R3,
    input  logic [3:0] R2,
    input  logic [3:0] R1,
    input  logic [3:0] R0,
    input  logic       hold,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic             wrap_c;
    logic             load_c;
    logic [3:0]       digit_val_c;

    assign wrap_c = (div_cnt_q == CNT_MAX);
    assign load_c = wrap_c && (digit_q == 2'd3) && !hold;

    // Slot prescaler and digit index
    always_comb begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
        digit_d   = digit_q;
        if (wrap_c) begin
            div_cnt_d = '0;
            digit_d   = digit_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            digit_q   <= 2'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
            digit_q   <= digit_d;
        end
    end

    // Snapshot only at the end of digit 3's slot so a scan is never torn
    always_comb begin
        shadow_d = shadow_q;
        if (load_c) begin
            shadow_d = {R3, R2, R1, R0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign digit_val_c = shadow_q[digit_q];

    hex_to_7seg u_hex_to_7seg (
        .hex (digit_val_c),
        .seg (SEG)
    );

    // Outputs decode registered state only; anodes dark during blanking
    always_comb begin
        AN = ANODE_OFF;
        if (32'(div_cnt_q) >= BLANK) begin
            AN = ~(4'b0001 << digit_q);
        end
    end

    assign DP = 1'b1;

endmodule

// File: tb/tb_reg_display_scan.sv
// Directed bench for reg_display_scan: reset, scan order, snapshot window,
// hold, full decode (REFRESH_DIV=4, BLANK=1) and a no-blank instance (2,0).
module tb_reg_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] r3, r2, r1, r0;
    logic       hold;
    logic [3:0] an, an0;
    logic [6:0] seg, seg0;
    logic       dp, dp0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_display_scan #(.REFRESH_DIV(4), .BLANK(1)) u_dut (
        .clk (clk), .rst (rst),
        .R3 (r3), .R2 (r2), .R1 (r1), .R0 (r0),
        .hold (hold),
        .AN (an), .SEG (seg), .DP (dp)
    );

    reg_display_scan #(.REFRESH_DIV(2), .BLANK(0)) u_dut_nb (
        .clk (clk), .rst (rst),
        .R3 (r3), .R2 (r2), .R1 (r1), .R0 (r0),
        .hold (hold),
        .AN (an0), .SEG (seg0), .DP (dp0)
    );

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] an_tab [4]   = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Walk one 16-cycle scan starting at digit 0, div_cnt 0; optionally
    // change R0/hold at cycle chg_i (inputs settle long before the load edge).
    task automatic check_scan(input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3,
                              input int chg_i, input logic [3:0] r0_v, input logic hold_v);
        logic [6:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 16; i++) begin
            if (i == chg_i) begin
                r0   = r0_v;
                hold = hold_v;
            end
            check_eq("scan_an", 32'(an), (i % 4 == 0) ? 32'hF : 32'(an_tab[i / 4]));
            check_eq("scan_seg", 32'(seg), 32'(e[i / 4]));
            check_eq("noblank_an", 32'(an0), 32'(an_tab[(i / 2) % 4]));
            step();
        end
        check_eq("dp", 32'(dp), 32'h1);
    endtask

    initial begin
        logic [6:0] prev;
        rst  = 1'b1;
        hold = 1'b0;
        {r3, r2, r1, r0} = {4'h1, 4'h2, 4'h3, 4'h4};

        @(negedge clk);
        check_eq("rst_an", 32'(an), 32'hF);
        check_eq("rst_seg", 32'(seg), 32'h40);
        check_eq("rst_dp", 32'(dp), 32'h1);
        check_eq("rst_an_noblank", 32'(an0), 32'hE);
        rst = 1'b0;
        check_eq("rel_an_blank", 32'(an), 32'hF);
        step();
        check_eq("rel_an_lit", 32'(an), 32'hE);
        check_eq("rel_seg", 32'(seg), 32'h40);
        step();

        // Mid-slot reset is immediate
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_an", 32'(an), 32'hF);
        check_eq("midrst_seg", 32'(seg), 32'h40);
        check_eq("midrst_an_noblank", 32'(an0), 32'hE);
        @(negedge clk);
        rst = 1'b0;

        // No priming load: first scan dark shadows, then 1,2,3,4
        check_scan(7'h40, 7'h40, 7'h40, 7'h40, -1, 4'h4, 1'b0);
        check_scan(7'h19, 7'h30, 7'h24, 7'h79, -1, 4'h4, 1'b0);
        // Mid-scan change of R0 only visible after the next load
        check_scan(7'h19, 7'h30, 7'h24, 7'h79, 6, 4'hF, 1'b0);
        check_scan(7'h0E, 7'h30, 7'h24, 7'h79, 6, 4'h8, 1'b1);
        // Hold across the load edge freezes the display
        check_scan(7'h0E, 7'h30, 7'h24, 7'h79, 6, 4'h8, 1'b0);
        check_scan(7'h00, 7'h30, 7'h24, 7'h79, -1, 4'h8, 1'b0);

        // Full decode through digit 0, one value per scan
        prev = 7'h00;
        for (int v = 0; v < 16; v++) begin
            check_scan(prev, 7'h30, 7'h24, 7'h79, 3, 4'(v), 1'b0);
            prev = seg_tab[v];
        end
        check_scan(prev, 7'h30, 7'h24, 7'h79, -1, 4'hF, 1'b0);

        // Reset with non-zero shadows while digit 1 is lit
        repeat (6) step();
        check_eq("pre_rst_an", 32'(an), 32'hD);
        check_eq("pre_rst_seg", 32'(seg), 32'h30);
        #2 rst = 1'b1;
        #1;
        check_eq("rst2_an", 32'(an), 32'hF);
        check_eq("rst2_seg", 32'(seg), 32'h40);
        check_eq("rst2_dp", 32'(dp), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        check_scan(7'h40, 7'h40, 7'h40, 7'h40, -1, 4'hF, 1'b0);
        check_scan(7'h0E, 7'h30, 7'h24, 7'h79, -1, 4'hF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
